// File: rtl/led_blink_encoder.sv
// Blink-train encoder: shows a status code as N LED pulses followed by a dark gap,
// optionally replaying the last accepted code until a new one arrives.
module led_blink_encoder #(
  parameter int unsigned CodeWidth    = 4,
  parameter logic [31:0] OnCycles     = 32'd1,
  parameter logic [31:0] OffCycles    = 32'd1,
  parameter logic [31:0] GapCycles    = 32'd1,
  parameter bit          AutoRepeat   = 1'b1,
  parameter bit          LedActiveLow = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CodeWidth-1:0] code,
  input  logic                 code_valid,
  output logic                 code_ready,
  output logic                 led,
  output logic                 busy,
  output logic                 seq_done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOn   = 2'd1;
  localparam logic [1:0] StOff  = 2'd2;
  localparam logic [1:0] StGap  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [CodeWidth-1:0] pulses_q, pulses_d;
  logic [CodeWidth-1:0] code_q, code_d;
  logic                 have_code_q, have_code_d;
  logic                 done_q, done_d;
  logic                 start;
  logic [CodeWidth-1:0] start_code;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulses_d    = pulses_q;
    code_d      = code_q;
    have_code_d = have_code_q;
    done_d      = 1'b0;
    start       = 1'b0;
    start_code  = code_q;

    case (state_q)
      StIdle: begin
        // A freshly offered code takes priority over replaying the latched one.
        if (code_valid) begin
          code_d      = code;
          have_code_d = 1'b1;
          start_code  = code;
          start       = 1'b1;
        end else if (AutoRepeat && have_code_q) begin
          start = 1'b1;
        end
        if (start) begin
          if (start_code != '0) begin
            state_d  = StOn;
            pulses_d = start_code;
            cnt_d    = OnCycles - 32'd1;
          end else begin
            state_d = StGap;
            cnt_d   = GapCycles - 32'd1;
          end
        end
      end
      StOn: begin
        if (cnt_q == 32'd0) begin
          state_d  = StOff;
          cnt_d    = OffCycles - 32'd1;
          pulses_d = pulses_q - 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StOff: begin
        if (cnt_q == 32'd0) begin
          if (pulses_q == '0) begin
            state_d = StGap;
            cnt_d   = GapCycles - 32'd1;
          end else begin
            state_d = StOn;
            cnt_d   = OnCycles - 32'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StGap: begin
        if (cnt_q == 32'd0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 32'd0;
      pulses_q    <= '0;
      code_q      <= '0;
      have_code_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulses_q    <= pulses_d;
      code_q      <= code_d;
      have_code_q <= have_code_d;
      done_q      <= done_d;
    end
  end

  assign led        = (state_q == StOn) ^ LedActiveLow;
  assign code_ready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign seq_done   = done_q;

endmodule

// File: tb/tb_led_blink_encoder.sv
// Directed bench for led_blink_encoder: two instances (auto-repeat active-high,
// one-shot active-low) with On=2, Off=3, Gap=10.
module tb_led_blink_encoder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       r_reset = 1'b0, r_valid = 1'b0;
  logic [3:0] r_code = 4'd0;
  logic       r_ready, r_led, r_busy, r_done;

  logic       o_reset = 1'b0, o_valid = 1'b0;
  logic [3:0] o_code = 4'd0;
  logic       o_ready, o_led, o_busy, o_done;

  int n_checks = 0;
  int n_fail   = 0;

  led_blink_encoder #(
    .CodeWidth(4), .OnCycles(32'd2), .OffCycles(32'd3), .GapCycles(32'd10),
    .AutoRepeat(1'b1), .LedActiveLow(1'b0)
  ) u_rep (
    .clk(clk), .reset(r_reset), .code(r_code), .code_valid(r_valid),
    .code_ready(r_ready), .led(r_led), .busy(r_busy), .seq_done(r_done)
  );

  led_blink_encoder #(
    .CodeWidth(4), .OnCycles(32'd2), .OffCycles(32'd3), .GapCycles(32'd10),
    .AutoRepeat(1'b0), .LedActiveLow(1'b1)
  ) u_one (
    .clk(clk), .reset(o_reset), .code(o_code), .code_valid(o_valid),
    .code_ready(o_ready), .led(o_led), .busy(o_busy), .seq_done(o_done)
  );

  // k counts cycles after acceptance (1 = first busy cycle); pulse period is On+Off=5.
  function automatic logic lit_at(int n, int k);
    return (k <= n * 5) && (((k - 1) % 5) < 2);
  endfunction

  task automatic test_reset;
    logic [3:0] got;
    r_reset = 1'b1; o_reset = 1'b1;
    @(negedge clk);
    r_reset = 1'b0; o_reset = 1'b0;
    got = {r_led, r_busy, r_ready, r_done};
    n_checks++;
    if (got !== 4'b0010) begin
      n_fail++; $display("FAIL reset_rep got=%b exp=%b", got, 4'b0010);
    end
    got = {o_led, o_busy, o_ready, o_done};
    n_checks++;
    if (got !== 4'b1010) begin
      n_fail++; $display("FAIL reset_one got=%b exp=%b", got, 4'b1010);
    end
  endtask

  task automatic test_auto_repeat;
    logic [3:0] got, exp;
    int p;
    r_reset = 1'b1;
    @(negedge clk);
    r_reset = 1'b0; r_code = 4'd3; r_valid = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk);
      r_valid = 1'b0;
      p   = ((k - 1) % 26) + 1;
      exp = (p == 26) ? 4'b0011 : {lit_at(3, p), 3'b100};
      got = {r_led, r_busy, r_ready, r_done};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL auto_repeat k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_code_zero;
    logic [3:0] got, exp;
    r_reset = 1'b1;
    @(negedge clk);
    r_reset = 1'b0; r_code = 4'd0; r_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      r_valid = 1'b0;
      exp = (k == 11) ? 4'b0011 : 4'b0100;
      got = {r_led, r_busy, r_ready, r_done};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL code_zero k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] got, exp;
    r_reset = 1'b1;
    @(negedge clk);
    r_reset = 1'b0; r_code = 4'd2; r_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      r_valid = 1'b0;
      exp = {lit_at(2, k), 3'b100};
      got = {r_led, r_busy, r_ready, r_done};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL reset_mid_run k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    r_reset = 1'b1;  // k=6 is the first ON cycle of pulse 2
    @(negedge clk);
    r_reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      got = {r_led, r_busy, r_ready, r_done};
      n_checks++;
      if (got !== 4'b0010) begin
        n_fail++; $display("FAIL reset_mid_idle k=%0d got=%b exp=%b", k, got, 4'b0010);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single;
    logic [3:0] got, exp;
    o_reset = 1'b1;
    @(negedge clk);
    o_reset = 1'b0; o_code = 4'd1; o_valid = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      o_valid = 1'b0;
      if (k <= 15)      exp = {~lit_at(1, k), 3'b100};
      else if (k == 16) exp = 4'b1011;
      else              exp = 4'b1010;
      got = {o_led, o_busy, o_ready, o_done};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL single k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] got, exp;
    o_reset = 1'b1;
    @(negedge clk);
    o_reset = 1'b0; o_code = 4'd2; o_valid = 1'b1;
    // Code 2 runs 20 busy cycles; 5 is offered from k=3 and must wait for IDLE at k=21.
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 3) o_code = 4'd5;
      exp = (k == 21) ? 4'b1011 : {~lit_at(2, k), 3'b100};
      got = {o_led, o_busy, o_ready, o_done};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL b2b_first k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      o_valid = 1'b0;
      if (k <= 35)      exp = {~lit_at(5, k), 3'b100};
      else if (k == 36) exp = 4'b1011;
      else              exp = 4'b1010;
      got = {o_led, o_busy, o_ready, o_done};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL b2b_second k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_auto_repeat();
    test_code_zero();
    test_reset_mid();
    test_single();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
